// File: rtl/k_and_s_pkg.sv
// K&S data path shared definitions: decoded instruction enum, opcodes, ALU ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_BRANCH,
      I_BZERO,
      I_BNEG,
      I_BNNEG,
      I_BNZERO,
      I_HALT
   } decoded_instruction_type;

   localparam logic [7:0] OPC_NOP    = 8'h00;
   localparam logic [7:0] OPC_BRANCH = 8'h01;
   localparam logic [7:0] OPC_BZERO  = 8'h02;
   localparam logic [7:0] OPC_BNEG   = 8'h03;
   localparam logic [7:0] OPC_BNNEG  = 8'h0A;
   localparam logic [7:0] OPC_BNZERO = 8'h0B;
   localparam logic [7:0] OPC_LOAD   = 8'h81;
   localparam logic [7:0] OPC_STORE  = 8'h82;
   localparam logic [7:0] OPC_MOVE   = 8'h91;
   localparam logic [7:0] OPC_ADD    = 8'hA1;
   localparam logic [7:0] OPC_SUB    = 8'hA2;
   localparam logic [7:0] OPC_AND    = 8'hA3;
   localparam logic [7:0] OPC_OR     = 8'hA4;
   localparam logic [7:0] OPC_HALT   = 8'hFF;

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // Unlisted opcodes fall back to NOP so a corrupted IR cannot trigger writes.
   function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
      case (opc)
         OPC_BRANCH: decode_opcode = I_BRANCH;
         OPC_BZERO:  decode_opcode = I_BZERO;
         OPC_BNEG:   decode_opcode = I_BNEG;
         OPC_BNNEG:  decode_opcode = I_BNNEG;
         OPC_BNZERO: decode_opcode = I_BNZERO;
         OPC_LOAD:   decode_opcode = I_LOAD;
         OPC_STORE:  decode_opcode = I_STORE;
         OPC_MOVE:   decode_opcode = I_MOVE;
         OPC_ADD:    decode_opcode = I_ADD;
         OPC_SUB:    decode_opcode = I_SUB;
         OPC_AND:    decode_opcode = I_AND;
         OPC_OR:     decode_opcode = I_OR;
         OPC_HALT:   decode_opcode = I_HALT;
         default:    decode_opcode = I_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ks_data_path_p_if.sv
// Control-unit / RAM bundle of the K&S data path.
// Latency: n/a (wires only). slave = data path side, master = control unit + RAM side.
// Backpressure: none; the control unit sequences every cycle explicitly.
interface ks_data_path_p_if
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) ();
   // control strobes and selects
   logic                    branch;
   logic                    pc_enable;
   logic                    ir_enable;
   logic                    addr_sel;
   logic                    c_sel;
   logic [1:0]              operation;
   logic                    write_reg_enable;
   logic                    flags_reg_enable;
   // status back to the control unit
   decoded_instruction_type decoded_instruction;
   logic                    zero_op;
   logic                    neg_op;
   logic                    unsigned_overflow;
   logic                    signed_overflow;
   // RAM side
   logic [ADDR_W-1:0]       ram_addr;
   logic [DATA_W-1:0]       data_out;
   logic [DATA_W-1:0]       data_in;

   modport master (
      output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
             write_reg_enable, flags_reg_enable, data_in,
      input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
             signed_overflow, ram_addr, data_out
   );

   modport slave (
      input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
             write_reg_enable, flags_reg_enable, data_in,
      output decoded_instruction, zero_op, neg_op, unsigned_overflow,
             signed_overflow, ram_addr, data_out
   );
endinterface

// File: rtl/ks_alu.sv
// K&S ALU: OR/ADD/SUB/AND with zero, negative, carry/borrow and signed-overflow flags.
// Latency: combinational. Ports: i_a, i_b, i_op in; o_result and four raw flags out.
// Backpressure: none.
module ks_alu
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [1:0]        i_op,
   output logic [DATA_W-1:0] o_result,
   output logic              o_zero,
   output logic              o_neg,
   output logic              o_uov,
   output logic              o_sov
);

   // One extra bit catches carry-out on ADD and borrow (A <u B) on SUB.
   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      o_result = '0;
      o_uov    = 1'b0;
      o_sov    = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_result = w_sum[DATA_W-1:0];
            o_uov    = w_sum[DATA_W];
            o_sov    = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != i_a[DATA_W-1]);
         end
         OP_SUB: begin
            o_result = w_diff[DATA_W-1:0];
            o_uov    = w_diff[DATA_W];
            o_sov    = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != i_a[DATA_W-1]);
         end
         OP_AND:  o_result = i_a & i_b;
         default: o_result = i_a | i_b;
      endcase
   end

   assign o_zero = (o_result == '0);
   assign o_neg  = o_result[DATA_W-1];

endmodule

// File: rtl/ks_data_path_p.sv
// K&S data path: IR + decoder, register file, ALU + flags register, PC with branch mux, RAM address mux.
// Latency: state updates on the clk edge; decode, bus reads, ALU and RAM address are combinational.
// Backpressure: none; clk/rst plain ports, everything else on the ks_data_path_p_if slave modport.
module ks_data_path_p
   import k_and_s_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 4
) (
   input  logic           clk,
   input  logic           rst,
   ks_data_path_p_if.slave bus
);

   localparam int REG_W = $clog2(NUM_REGS);

   if (DATA_W < 16 || NUM_REGS < 2 || (1 << REG_W) != NUM_REGS ||
       3*REG_W > DATA_W-8 || ADDR_W+REG_W > DATA_W-8) begin : g_bad_cfg
      $error("ks_data_path_p: illegal DATA_W/ADDR_W/NUM_REGS combination");
   end

   logic [DATA_W-1:0]       r_ir;
   logic [ADDR_W-1:0]       r_pc;
   logic [DATA_W-1:0]       r_regs [NUM_REGS];
   logic                    r_zero;
   logic                    r_neg;
   logic                    r_uov;
   logic                    r_sov;

   decoded_instruction_type w_dec;
   logic [ADDR_W-1:0]       w_mem_addr;
   logic [REG_W-1:0]        w_sel_a;
   logic [REG_W-1:0]        w_sel_b;
   logic [REG_W-1:0]        w_sel_c;
   logic [DATA_W-1:0]       w_bus_a;
   logic [DATA_W-1:0]       w_bus_b;
   logic [DATA_W-1:0]       w_bus_c;
   logic [DATA_W-1:0]       w_alu_res;
   logic                    w_alu_zero;
   logic                    w_alu_neg;
   logic                    w_alu_uov;
   logic                    w_alu_sov;
   logic                    w_ir_unused;

   // ---------------- instruction register and decode ----------------
   always_ff @(posedge clk) begin
      if (rst)               r_ir <= '0;
      else if (bus.ir_enable) r_ir <= bus.data_in;
   end

   assign w_dec      = decode_opcode(r_ir[DATA_W-1 -: 8]);
   assign w_mem_addr = r_ir[ADDR_W-1:0];

   // Register selects are always driven; the ALU-format layout is the default
   // so the decode stays purely combinational.
   always_comb begin
      w_sel_a = r_ir[REG_W-1:0];
      w_sel_b = r_ir[2*REG_W-1:REG_W];
      w_sel_c = r_ir[3*REG_W-1:2*REG_W];
      case (w_dec)
         I_LOAD:  w_sel_c = r_ir[ADDR_W+REG_W-1:ADDR_W];
         I_STORE: w_sel_a = r_ir[ADDR_W+REG_W-1:ADDR_W];
         I_MOVE: begin
            w_sel_b = r_ir[REG_W-1:0];
            w_sel_c = r_ir[2*REG_W-1:REG_W];
         end
         default: ;
      endcase
   end

   // Bits between the register fields and the opcode carry no meaning.
   assign w_ir_unused = ^r_ir;

   // ---------------- register file ----------------
   assign w_bus_a = r_regs[w_sel_a];
   assign w_bus_b = r_regs[w_sel_b];
   assign w_bus_c = bus.c_sel ? bus.data_in : w_alu_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (bus.write_reg_enable) begin
         r_regs[w_sel_c] <= w_bus_c;
      end
   end

   // ---------------- ALU and flags ----------------
   ks_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a      (w_bus_a),
      .i_b      (w_bus_b),
      .i_op     (bus.operation),
      .o_result (w_alu_res),
      .o_zero   (w_alu_zero),
      .o_neg    (w_alu_neg),
      .o_uov    (w_alu_uov),
      .o_sov    (w_alu_sov)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_uov  <= 1'b0;
         r_sov  <= 1'b0;
      end else if (bus.flags_reg_enable) begin
         r_zero <= w_alu_zero;
         r_neg  <= w_alu_neg;
         r_uov  <= w_alu_uov;
         r_sov  <= w_alu_sov;
      end
   end

   // ---------------- program counter ----------------
   always_ff @(posedge clk) begin
      if (rst)               r_pc <= '0;
      else if (bus.pc_enable) r_pc <= bus.branch ? w_mem_addr : r_pc + 1'b1;
   end

   // ---------------- outputs ----------------
   assign bus.decoded_instruction = w_dec;
   assign bus.zero_op             = r_zero;
   assign bus.neg_op              = r_neg;
   assign bus.unsigned_overflow   = r_uov;
   assign bus.signed_overflow     = r_sov;
   assign bus.ram_addr            = bus.addr_sel ? r_pc : w_mem_addr;
   assign bus.data_out            = w_bus_a;

endmodule
